// File: rtl/restoring_divider_pkg.sv
// rtl/restoring_divider_pkg.sv - shared state encodings and counter sizing for restoring_divider
package restoring_divider_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Iteration counter must hold the value N itself, hence N+1 codes.
  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/restoring_divider_trial_subtractor.sv
// rtl/restoring_divider_trial_subtractor.sv - W-bit a-b as a full-adder chain, b inverted, carry-in 1
module trial_subtractor #(
  parameter int W = 5
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] diff,
  output logic         no_borrow
);

  logic [W:0] carry;

  assign carry[0] = 1'b1;

  // One full-adder cell per bit; carry-out of the top cell is 1 when a >= b.
  for (genvar i = 0; i < W; i++) begin : g_fa
    logic b_inv;
    assign b_inv      = ~b[i];
    assign diff[i]    = a[i] ^ b_inv ^ carry[i];
    assign carry[i+1] = (a[i] & b_inv) | (carry[i] & (a[i] ^ b_inv));
  end

  assign no_borrow = carry[W];

endmodule

// File: rtl/restoring_divider.sv
// rtl/restoring_divider.sv - sequential unsigned restoring divider, one quotient bit per clock; optional DIVZERO_CHECK_EN
module restoring_divider #(
  parameter int N = 8,
  parameter int M = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [N-1:0] dividend,
  input  logic [M-1:0] divisor,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] quotient,
  output logic [M-1:0] remainder,
  output logic         div_by_zero
);

  import restoring_divider_pkg::*;

  localparam int CW = cnt_width(N);

  state_t         state;
  state_t         state_next;
  logic [M-1:0]   r_reg;
  logic [N-1:0]   q_reg;
  logic [M-1:0]   d_reg;
  logic [CW-1:0]  cnt;

  logic [M:0]     trial;
  logic [M:0]     diff;
  logic           no_borrow;
  logic [M-1:0]   r_next;
  logic [N-1:0]   q_next;
  logic           last_iter;
  logic           zero_div;
  logic           diff_unused;

  // Partial remainder with the next dividend bit shifted in.
  assign trial = {r_reg, q_reg[N-1]};

  trial_subtractor #(.W(M + 1)) u_sub (
    .a         (trial),
    .b         ({1'b0, d_reg}),
    .diff      (diff),
    .no_borrow (no_borrow)
  );

  // When the difference is kept it is below the divisor, so its top bit is always zero.
  assign diff_unused = diff[M];
  assign r_next      = no_borrow ? diff[M-1:0] : trial[M-1:0];
  assign q_next      = {q_reg[N-2:0], no_borrow};
  assign last_iter   = (cnt == CW'(1));

`ifdef DIVZERO_CHECK_EN
  assign zero_div = (divisor == '0);
`else
  assign zero_div = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and status outputs.
  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          state_next = zero_div ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN: begin
        busy = 1'b1;
        if (last_iter) begin
          state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        busy       = 1'b1;
        done       = 1'b1;
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

`ifdef DIVZERO_CHECK_EN
  logic dbz_reg;
  assign div_by_zero = dbz_reg;
`else
  assign div_by_zero = 1'b0;
`endif

  // Operand capture, iteration datapath and result registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_reg     <= '0;
      q_reg     <= '0;
      d_reg     <= '0;
      cnt       <= '0;
      quotient  <= '0;
      remainder <= '0;
`ifdef DIVZERO_CHECK_EN
      dbz_reg   <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            r_reg <= '0;
            q_reg <= dividend;
            d_reg <= divisor;
            cnt   <= CW'(N);
`ifdef DIVZERO_CHECK_EN
            dbz_reg <= zero_div;
            if (zero_div) begin
              quotient  <= '1;
              remainder <= '0;
            end
`endif
          end
        end
        ST_RUN: begin
          r_reg <= r_next;
          q_reg <= q_next;
          cnt   <= cnt - CW'(1);
          if (last_iter) begin
            quotient  <= q_next;
            remainder <= r_next;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_restoring_divider.sv
// tb/tb_restoring_divider.sv - directed self-checking bench for restoring_divider (honours DIVZERO_CHECK_EN)
module tb_restoring_divider;

  localparam int N = 8;
  localparam int M = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [N-1:0] dividend;
  logic [M-1:0] divisor;
  logic         busy;
  logic         done;
  logic [N-1:0] quotient;
  logic [M-1:0] remainder;
  logic         div_by_zero;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  restoring_divider #(.N(N), .M(M)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input logic [N-1:0] dd, input logic [M-1:0] dv, input int exp_q,
                        input int exp_r, input int exp_lat, input int exp_dz, input string tag);
    int k;
    dividend = dd;
    divisor  = dv;
    start    = 1'b1;
    tick();
    start = 1'b0;
    k = 0;
    while (!done && k < 20) begin
      tick();
      k++;
    end
    chk({tag, ".latency"}, k, exp_lat);
    chk({tag, ".quotient"}, quotient, exp_q);
    chk({tag, ".remainder"}, remainder, exp_r);
    chk({tag, ".div_by_zero"}, div_by_zero, exp_dz);
    tick();
    chk({tag, ".idle_busy"}, busy, 0);
  endtask

  initial begin
    int pulses;
    int last_done;
    int k;
    int na;
    int nb;

    reset    = 1'b1;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    tick();
    tick();
    chk("reset.busy", busy, 0);
    chk("reset.done", done, 0);
    chk("reset.quotient", quotient, 0);
    chk("reset.remainder", remainder, 0);
    chk("reset.div_by_zero", div_by_zero, 0);
    reset = 1'b0;
    tick();
    chk("idle.busy", busy, 0);

    // 200/7 with a cycle-by-cycle busy/done trace
    dividend = 8'd200;
    divisor  = 4'd7;
    start    = 1'b1;
    tick();
    start = 1'b0;
    chk("t1.busy_e0", busy, 1);
    chk("t1.done_e0", done, 0);
    for (int i = 1; i <= 8; i++) begin
      tick();
      chk($sformatf("t1.busy_e%0d", i), busy, 1);
      chk($sformatf("t1.done_e%0d", i), done, (i == 8) ? 1 : 0);
    end
    chk("t1.quotient", quotient, 28);
    chk("t1.remainder", remainder, 4);
    tick();
    chk("t1.busy_e9", busy, 0);
    chk("t1.done_e9", done, 0);

    // Assorted quotients
    run_op(8'd5, 4'd9, 0, 5, 8, 0, "t2a");
    run_op(8'd0, 4'd1, 0, 0, 8, 0, "t2b");
    run_op(8'd255, 4'd15, 17, 0, 8, 0, "t2c");

    // 100/3 with a stray start and operand changes mid-run
    dividend = 8'd100;
    divisor  = 4'd3;
    start    = 1'b1;
    tick();
    start    = 1'b0;
    dividend = 8'd255;
    divisor  = 4'd1;
    tick();
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("t3.held_quotient", quotient, 17);
    chk("t3.held_remainder", remainder, 0);
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (done) pulses++;
    end
    chk("t3.done_pulses", pulses, 1);
    chk("t3.quotient", quotient, 33);
    chk("t3.remainder", remainder, 1);
    chk("t3.busy_end", busy, 0);

    // Reset at edge 4 of 200/7
    dividend = 8'd200;
    divisor  = 4'd7;
    start    = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("t4.busy", busy, 0);
    chk("t4.done", done, 0);
    chk("t4.quotient", quotient, 0);
    chk("t4.remainder", remainder, 0);
    chk("t4.div_by_zero", div_by_zero, 0);
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (done) pulses++;
    end
    chk("t4.no_done", pulses, 0);
    run_op(8'd50, 4'd6, 8, 2, 8, 0, "t4b");

    // Divide by zero
`ifdef DIVZERO_CHECK_EN
    run_op(8'd37, 4'd0, 255, 0, 0, 1, "t5");
    chk("t5.dbz_held", div_by_zero, 1);
    chk("t5.quotient_held", quotient, 255);
`else
    run_op(8'd37, 4'd0, 255, 5, 8, 0, "t5");
`endif

    // Back-to-back sweep of all nonzero divisors
    last_done = -1;
    dividend  = 8'd0;
    divisor   = 4'd1;
    start     = 1'b1;
    for (int a = 0; a < 256; a++) begin
      for (int b = 1; b < 16; b++) begin
        k = 0;
        while (!done && k < 30) begin
          tick();
          k++;
        end
        chk($sformatf("sweep.done %0d/%0d", a, b), done, 1);
        chk($sformatf("sweep.invariant %0d/%0d", a, b),
            ((int'(quotient) * b + int'(remainder) == a) && (int'(remainder) < b)) ? 1 : 0, 1);
        chk($sformatf("sweep.div_by_zero %0d/%0d", a, b), div_by_zero, 0);
        if (last_done >= 0) begin
          chk($sformatf("sweep.spacing %0d/%0d", a, b), cyc - last_done, N + 2);
        end
        last_done = cyc;
        if (b < 15) begin
          na = a;
          nb = b + 1;
        end else begin
          na = a + 1;
          nb = 1;
        end
        dividend = na[N-1:0];
        divisor  = nb[M-1:0];
        tick();
      end
    end
    start = 1'b0;
    tick();
    tick();
    chk("sweep.end_busy", busy, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
